// File: rtl/hd44780_nybble_sender.sv
// Drives one 4-bit HD44780 bus transfer: latches RS/data, then runs the
// setup, E-high and hold phases from a down-counter and emits a done strobe.
module hd44780_nybble_sender #(
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int HOLD_CYCLES   = 12,
  parameter int CTR_BITS      = 8
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [3:0] DAT_I,
  input  logic       rs_i,
  input  logic       start_strobe,
  output logic       busy,
  output logic       end_strobe,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_data
);

  // A zero-length phase is stretched to one cycle so every phase is observable.
  localparam int S_LEN = (SETUP_CYCLES  == 0) ? 1 : SETUP_CYCLES;
  localparam int E_LEN = (E_HIGH_CYCLES == 0) ? 1 : E_HIGH_CYCLES;
  localparam int H_LEN = (HOLD_CYCLES   == 0) ? 1 : HOLD_CYCLES;

  localparam logic [CTR_BITS-1:0] S_LOAD = CTR_BITS'(S_LEN - 1);
  localparam logic [CTR_BITS-1:0] E_LOAD = CTR_BITS'(E_LEN - 1);
  localparam logic [CTR_BITS-1:0] H_LOAD = CTR_BITS'(H_LEN - 1);
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EHIGH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [CTR_BITS-1:0] ctr_r;
  logic                start_q_r;
  logic                start_s;

  // Rising edge of the request strobe.
  assign start_s = start_strobe & ~start_q_r;

  // Transfer sequencer; all pin outputs come straight from these flops.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_r    <= ST_IDLE;
      ctr_r      <= '0;
      start_q_r  <= 1'b0;
      busy       <= 1'b0;
      end_strobe <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_data   <= 4'h0;
    end else begin
      start_q_r <= start_strobe;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          end_strobe <= 1'b0;
          if (start_s) begin
            lcd_data <= DAT_I;
            lcd_rs   <= rs_i;
            busy     <= 1'b1;
            ctr_r    <= S_LOAD;
            state_r  <= ST_SETUP;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (ctr_r == '0) begin
            lcd_e   <= 1'b1;
            ctr_r   <= E_LOAD;
            state_r <= ST_EHIGH;
          end else begin
            ctr_r   <= ctr_r - CTR_ONE;
          end
        end
        ST_EHIGH: begin
          if (ctr_r == '0) begin
            lcd_e   <= 1'b0;
            ctr_r   <= H_LOAD;
            state_r <= ST_HOLD;
          end else begin
            ctr_r   <= ctr_r - CTR_ONE;
          end
        end
        ST_HOLD: begin
          if (ctr_r == '0) begin
            end_strobe <= 1'b1;
            busy       <= 1'b0;
            state_r    <= ST_DONE;
          end else begin
            ctr_r      <= ctr_r - CTR_ONE;
          end
        end
        default: begin
          lcd_e      <= 1'b0;
          busy       <= 1'b0;
          end_strobe <= 1'b0;
          ctr_r      <= '0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
